// File: rtl/riscv_aes_wb_burst_if.sv
// Memory write-port bundle between the AES write-back engine and the LSU.
// The engine drives request/address/data/byte-enables; memory answers with grant.
interface riscv_aes_wb_burst_if #(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic [WORD_W-1:0]     data;
    logic [WORD_W/8-1:0]   be;

    modport master (output req, addr, data, be, input gnt);
    modport slave  (input req, addr, data, be, output gnt);
endinterface

// File: rtl/riscv_aes_wb_burst.sv
// AES result write-back engine: captures a DATA_W block on start and streams it
// to the data-memory port as NWORDS ascending word writes over req/gnt, holding
// the core halted until an optional settle period has elapsed.
module riscv_aes_wb_burst #(
    parameter int DATA_W        = 128,
    parameter int WORD_W        = 32,
    parameter int ADDR_W        = 32,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic [DATA_W-1:0]      data_i,
    input  logic                   msw_first_i,
    riscv_aes_wb_burst_if.master   wr,
    output logic                   halt_o,
    output logic                   done_o,
    output logic                   start_err_o
);

    localparam int NWORDS      = (DATA_W / WORD_W) < 1 ? 1 : (DATA_W / WORD_W);
    localparam int STRIDE      = WORD_W / 8;
    localparam int IDX_W       = NWORDS > 1 ? $clog2(NWORDS) : 1;
    localparam int CNT_W       = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SETTLE_LAST = SETTLE_CYCLES > 0 ? SETTLE_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SETTLE,
        FINISH
    } state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [CNT_W-1:0]    settle_cnt;
    logic [DATA_W-1:0]   data_q;
    logic                msw_q;

    // Select the word for write position pos; MSW-first mode only reverses the
    // data slice, the address sequence is always ascending.
    function automatic logic [WORD_W-1:0] word_at(input logic [DATA_W-1:0] blk,
                                                  input int unsigned       pos,
                                                  input logic              msw);
        int unsigned slot;
        slot = msw ? (NWORDS - 1 - pos) : pos;
        return blk[slot*WORD_W +: WORD_W];
    endfunction

    // Burst sequencer; every output is a register so grant never reaches an output
    // combinationally, and the next word is prepared on the accepting edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            settle_cnt  <= '0;
            data_q      <= '0;
            msw_q       <= 1'b0;
            wr.req      <= 1'b0;
            wr.addr     <= '0;
            wr.data     <= '0;
            wr.be       <= '0;
            halt_o      <= 1'b0;
            done_o      <= 1'b0;
            start_err_o <= 1'b0;
        end else begin
            start_err_o <= start_i && (state != IDLE);
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        data_q  <= data_i;
                        msw_q   <= msw_first_i;
                        idx     <= '0;
                        wr.req  <= 1'b1;
                        wr.be   <= '1;
                        wr.addr <= addr_i;
                        wr.data <= word_at(data_i, 0, msw_first_i);
                        halt_o  <= 1'b1;
                        state   <= WRITE;
                    end
                end
                WRITE: begin
                    if (wr.gnt) begin
                        if (idx == IDX_W'(NWORDS - 1)) begin
                            idx    <= '0;
                            wr.req <= 1'b0;
                            wr.be  <= '0;
                            if (SETTLE_CYCLES > 0) begin
                                settle_cnt <= '0;
                                state      <= SETTLE;
                            end else begin
                                halt_o <= 1'b0;
                                done_o <= 1'b1;
                                state  <= FINISH;
                            end
                        end else begin
                            idx     <= idx + 1'b1;
                            wr.addr <= wr.addr + ADDR_W'(STRIDE);
                            wr.data <= word_at(data_q, 32'(idx) + 32'd1, msw_q);
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == CNT_W'(SETTLE_LAST)) begin
                        halt_o <= 1'b0;
                        done_o <= 1'b1;
                        state  <= FINISH;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
